// File: rtl/timer_irq_source_pkg.sv
// Shared peripheral definitions for the timer interrupt source: register map
// and bit positions within the CTRL and STATUS registers.
package timer_irq_source_pkg;

  localparam logic [2:0] ADDR_CNT_LO = 3'd0;
  localparam logic [2:0] ADDR_CNT_HI = 3'd1;
  localparam logic [2:0] ADDR_CTRL   = 3'd2;
  localparam logic [2:0] ADDR_STATUS = 3'd3;

  localparam int unsigned CTRL_EN        = 0;
  localparam int unsigned CTRL_IE        = 1;
  localparam int unsigned CTRL_ONESHOT   = 2;
  localparam int unsigned CTRL_PRESC_LSB = 4;

  localparam int unsigned STAT_EXP = 0;
  localparam int unsigned STAT_RUN = 1;

endpackage

// File: rtl/timer_prescaler.sv
// Power-of-two clock prescaler: emits a one-cycle tick every 2^select_i
// enabled cycles; clear_i restarts the phase and has priority over counting.
module timer_prescaler #(
  parameter int unsigned PRESC_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable_i,
  input  logic [PRESC_W-1:0] select_i,
  input  logic               clear_i,
  output logic               tick_o
);

  localparam int unsigned CNT_W = (1 << PRESC_W) - 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   one_hot;
  logic [CNT_W-1:0] limit;

  // Terminal count 2^select-1; computed one bit wider so the largest
  // select value wraps to all-ones instead of zero.
  always_comb begin
    one_hot = (CNT_W+1)'(1) << select_i;
    limit   = CNT_W'(one_hot - (CNT_W+1)'(1));
  end

  assign tick_o = enable_i & (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/timer_irq_source.sv
// Bus-mapped 16-bit down-counting timer raising a level-held, active-low
// interrupt request that stays asserted until software clears EXP.
module timer_irq_source
  import timer_irq_source_pkg::*;
#(
  parameter logic [15:0] RESET_RELOAD = 16'hFFFF,
  parameter int unsigned PRESC_W      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] i_data,
  output logic [7:0] o_data,
  input  logic       cs,
  input  logic       rwb,
  input  logic [2:0] addr,
  output logic       irqb
);

  logic [15:0]        count_q, count_d, reload_q, reload_d;
  logic               en_q, en_d, ie_q, ie_d, oneshot_q, oneshot_d;
  logic [PRESC_W-1:0] presc_q, presc_d, presc_wr;
  logic               exp_q, exp_d, irqb_q, irqb_d;
  logic [7:0]         snap_q, snap_d, rdata_q, rdata_d;
  logic [7:0]         ctrl_rd, stat_rd;
  logic               wr, rd, wr_lo, wr_hi, wr_ctrl, wr_stat;
  logic               presc_clr, tick, fire;

  always_comb begin
    wr       = cs & ~rwb;
    rd       = cs & rwb;
    wr_lo    = wr & (addr == ADDR_CNT_LO);
    wr_hi    = wr & (addr == ADDR_CNT_HI);
    wr_ctrl  = wr & (addr == ADDR_CTRL);
    wr_stat  = wr & (addr == ADDR_STATUS);
    presc_wr = i_data[CTRL_PRESC_LSB +: PRESC_W];
    presc_clr = wr_hi | (wr_ctrl & (presc_wr != presc_q));
    // A counter load or a write that stops the timer swallows this tick.
    fire = tick & ~wr_hi & ~(wr_ctrl & ~i_data[CTRL_EN]);
  end

  timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
    .clk      (clk),
    .reset    (reset),
    .enable_i (en_q),
    .select_i (presc_q),
    .clear_i  (presc_clr),
    .tick_o   (tick)
  );

  always_comb begin
    ctrl_rd                                = '0;
    ctrl_rd[CTRL_EN]                       = en_q;
    ctrl_rd[CTRL_IE]                       = ie_q;
    ctrl_rd[CTRL_ONESHOT]                  = oneshot_q;
    ctrl_rd[CTRL_PRESC_LSB +: PRESC_W]     = presc_q;
    stat_rd                                = '0;
    stat_rd[STAT_EXP]                      = exp_q;
    stat_rd[STAT_RUN]                      = en_q;
  end

  always_comb begin
    count_d   = count_q;
    reload_d  = reload_q;
    en_d      = en_q;
    ie_d      = ie_q;
    oneshot_d = oneshot_q;
    presc_d   = presc_q;
    exp_d     = exp_q;
    snap_d    = snap_q;
    rdata_d   = rdata_q;
    irqb_d    = ~(exp_q & ie_q);

    if (wr_lo) reload_d[7:0] = i_data;
    if (wr_hi) begin
      reload_d[15:8] = i_data;
      count_d        = {i_data, reload_q[7:0]};
    end
    if (wr_ctrl) begin
      en_d      = i_data[CTRL_EN];
      ie_d      = i_data[CTRL_IE];
      oneshot_d = i_data[CTRL_ONESHOT];
      presc_d   = presc_wr;
    end
    if (wr_stat && i_data[STAT_EXP]) exp_d = 1'b0;

    // Expiry is applied after the STATUS clear so a coincident set wins.
    if (fire) begin
      if (count_q != 16'd0) begin
        count_d = count_q - 16'd1;
      end else begin
        exp_d = 1'b1;
        if (oneshot_q) en_d = 1'b0;
        else           count_d = reload_q;
      end
    end

    if (rd) begin
      case (addr)
        ADDR_CNT_LO: begin
          rdata_d = count_q[7:0];
          snap_d  = count_q[15:8];
        end
        ADDR_CNT_HI: rdata_d = snap_q;
        ADDR_CTRL:   rdata_d = ctrl_rd;
        ADDR_STATUS: rdata_d = stat_rd;
        default:     rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q   <= RESET_RELOAD;
      reload_q  <= RESET_RELOAD;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      oneshot_q <= 1'b0;
      presc_q   <= '0;
      exp_q     <= 1'b0;
      snap_q    <= '0;
      rdata_q   <= '0;
      irqb_q    <= 1'b1;
    end else begin
      count_q   <= count_d;
      reload_q  <= reload_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      oneshot_q <= oneshot_d;
      presc_q   <= presc_d;
      exp_q     <= exp_d;
      snap_q    <= snap_d;
      rdata_q   <= rdata_d;
      irqb_q    <= irqb_d;
    end
  end

  assign o_data = rdata_q;
  assign irqb   = irqb_q;

endmodule

// File: tb/tb_timer_irq_source.sv
// Self-checking bench for timer_irq_source: directed scenarios with literal
// expectations plus randomized bus traffic against a cycle-level model.
module tb_timer_irq_source;

  localparam logic [15:0] RR = 16'hFFFF;

  logic       clk = 1'b0;
  logic       reset;
  logic       cs, rwb;
  logic [2:0] addr;
  logic [7:0] i_data, o_data;
  logic       irqb;

  int checks = 0;
  int passes = 0;
  bit cmp_on = 1'b0;

  timer_irq_source #(.RESET_RELOAD(RR), .PRESC_W(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .i_data (i_data),
    .o_data (o_data),
    .cs     (cs),
    .rwb    (rwb),
    .addr   (addr),
    .irqb   (irqb)
  );

  always #5 clk = ~clk;

  // Reference model: m_phase counts enabled cycles within the current
  // 2^PRESC period; everything else follows the register-level rules.
  logic [15:0] m_count, m_reload, n_count, n_reload;
  logic        m_en, m_ie, m_one, m_exp, m_irqb;
  logic        n_en, n_ie, n_one, n_exp;
  logic [2:0]  m_presc, n_presc;
  logic [7:0]  m_snap, m_odata, n_snap, n_odata;
  int          m_phase, n_phase;
  bit          tick, fired;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_count = RR; m_reload = RR; m_en = 0; m_ie = 0; m_one = 0;
      m_presc = 3'd0; m_phase = 0; m_exp = 0; m_snap = 8'h00;
      m_odata = 8'h00; m_irqb = 1;
    end else begin
      tick    = m_en && (m_phase == (1 << m_presc) - 1);
      n_phase = !m_en ? m_phase : (tick ? 0 : m_phase + 1);
      fired   = tick;
      n_count = m_count; n_reload = m_reload; n_en = m_en; n_ie = m_ie;
      n_one = m_one; n_presc = m_presc; n_exp = m_exp; n_snap = m_snap;
      n_odata = m_odata;
      if (cs && !rwb) begin
        case (addr)
          3'd0: n_reload[7:0] = i_data;
          3'd1: begin
            n_reload[15:8] = i_data;
            n_count = {i_data, m_reload[7:0]};
            n_phase = 0;
            fired = 0;
          end
          3'd2: begin
            n_en = i_data[0]; n_ie = i_data[1]; n_one = i_data[2];
            n_presc = i_data[6:4];
            if (i_data[6:4] != m_presc) n_phase = 0;
            if (!i_data[0]) fired = 0;
          end
          3'd3: if (i_data[0]) n_exp = 0;
          default: ;
        endcase
      end
      if (fired) begin
        if (m_count != 16'd0) n_count = m_count - 16'd1;
        else begin
          n_exp = 1;
          if (m_one) n_en = 0;
          else n_count = m_reload;
        end
      end
      if (cs && rwb) begin
        case (addr)
          3'd0: begin n_odata = m_count[7:0]; n_snap = m_count[15:8]; end
          3'd1: n_odata = m_snap;
          3'd2: n_odata = {1'b0, m_presc, 1'b0, m_one, m_ie, m_en};
          3'd3: n_odata = {6'b0, m_en, m_exp};
          default: n_odata = 8'h00;
        endcase
      end
      m_irqb = !(m_exp && m_ie);
      m_count = n_count; m_reload = n_reload; m_en = n_en; m_ie = n_ie;
      m_one = n_one; m_presc = n_presc; m_phase = n_phase; m_exp = n_exp;
      m_snap = n_snap; m_odata = n_odata;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Literal expectation applied to both the DUT and the model.
  task automatic pin(input string name, input logic [15:0] dut_v, input logic [15:0] mdl_v,
                     input logic [15:0] exp);
    check(name, dut_v, exp);
    check({name, "_model"}, mdl_v, exp);
  endtask

  always @(negedge clk) begin
    if (cmp_on) begin
      check("o_data", 16'(o_data), 16'(m_odata));
      check("irqb", 16'(irqb), 16'(m_irqb));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
    cyc(1);
    cs = 1'b0; rwb = 1'b1;
  endtask

  task automatic rdchk(input string name, input logic [2:0] a, input logic [7:0] exp);
    cs = 1'b1; rwb = 1'b1; addr = a;
    cyc(1);
    cs = 1'b0;
    pin(name, 16'(o_data), 16'(m_odata), 16'(exp));
  endtask

  task automatic irqchk(input string name, input logic exp);
    pin(name, 16'(irqb), 16'(m_irqb), 16'(exp));
  endtask

  initial begin
    reset = 1'b1; cs = 1'b0; rwb = 1'b1; addr = 3'd0; i_data = 8'h00;
    cyc(2);
    reset = 1'b0;
    cmp_on = 1'b1;
    irqchk("reset_irqb", 1'b1);
    pin("reset_odata", 16'(o_data), 16'(m_odata), 16'h00);

    // Periodic, reload 3, PRESC 0.
    wr(3'd0, 8'h03); wr(3'd1, 8'h00); wr(3'd2, 8'h03);
    cyc(4); irqchk("per_irqb_at_exp", 1'b1);
    cyc(1); irqchk("per_irqb_low", 1'b0);
    rdchk("per_status", 3'd3, 8'h03);
    wr(3'd3, 8'h01);
    cyc(1); irqchk("per_irqb_cleared", 1'b1);
    cyc(1); irqchk("per_irqb_again", 1'b0);
    cyc(2);
    wr(3'd3, 8'h01);                      // lands on an expiry edge
    irqchk("coll_irqb0", 1'b0);
    cyc(1); irqchk("coll_irqb1", 1'b0);
    rdchk("coll_status", 3'd3, 8'h03);

    // Asynchronous reset mid-count.
    #3 reset = 1'b1;
    #1 irqchk("async_rst_irqb", 1'b1);
    pin("async_rst_odata", 16'(o_data), 16'(m_odata), 16'h00);
    @(posedge clk); #1 reset = 1'b0;
    rdchk("rst_cnt_lo", 3'd0, 8'hFF);
    rdchk("rst_cnt_hi", 3'd1, 8'hFF);

    // One-shot, reload 2, PRESC 2: single expiry after 12 cycles.
    wr(3'd0, 8'h02); wr(3'd1, 8'h00); wr(3'd2, 8'h27);
    cyc(11); irqchk("os_before", 1'b1);
    cyc(1);  irqchk("os_at_exp", 1'b1);
    cyc(1);  irqchk("os_low", 1'b0);
    rdchk("os_ctrl", 3'd2, 8'h26);
    rdchk("os_status", 3'd3, 8'h01);
    rdchk("os_cnt_lo", 3'd0, 8'h00);
    rdchk("os_cnt_hi", 3'd1, 8'h00);
    wr(3'd3, 8'h01);
    cyc(40);
    rdchk("os_no_rearm", 3'd3, 8'h00);

    // Coherent 16-bit read across a borrow.
    wr(3'd0, 8'h00); wr(3'd1, 8'h01); wr(3'd2, 8'h01);
    rdchk("coh_lo", 3'd0, 8'h00);
    rdchk("coh_hi", 3'd1, 8'h01);
    rdchk("coh_lo2", 3'd0, 8'hFE);
    rdchk("coh_hi2", 3'd1, 8'h00);

    // Masked expiry, then enabling IE.
    wr(3'd2, 8'h00); wr(3'd3, 8'h01);
    wr(3'd0, 8'h01); wr(3'd1, 8'h00); wr(3'd2, 8'h01);
    cyc(5);
    rdchk("mask_status", 3'd3, 8'h03);
    irqchk("mask_irqb", 1'b1);
    wr(3'd2, 8'h03);
    irqchk("ie_set_irqb0", 1'b1);
    cyc(1); irqchk("ie_set_irqb1", 1'b0);

    // Randomized bus traffic; the negedge compare checks every cycle.
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 299) == 0);
      cs     = ($urandom_range(0, 3) == 0);
      rwb    = ($urandom_range(0, 2) != 0);
      addr   = 3'($urandom_range(0, 7));
      i_data = 8'($urandom);
      if (!rwb) begin
        case (addr)
          3'd0: i_data = 8'($urandom_range(0, 5));
          3'd1: i_data = ($urandom_range(0, 9) == 0) ? 8'($urandom) : 8'h00;
          3'd2: begin
            i_data[0] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) != 0) i_data[6:4] = 3'($urandom_range(0, 2));
          end
          default: ;
        endcase
      end
      cyc(1);
    end
    reset = 1'b0; cs = 1'b0;
    cyc(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
